// File: rtl/code_comb_stream.sv
// Field combiner with valid/ready output: latches a word plus two indices, then emits one
// {field[M],field[m]} beat (PAIR) or the walk field[M]..field[m] (SWEEP).
module code_comb_stream #(
   parameter int FIELD_W    = 4,
   parameter int NUM_FIELDS = 8,
   parameter int SEL_W      = 3
) (
   input  logic                          sysclk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          mode,
   input  logic [NUM_FIELDS*FIELD_W-1:0] data_in,
   input  logic [SEL_W-1:0]              hi_sel,
   input  logic [SEL_W-1:0]              lo_sel,
   output logic                          busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*FIELD_W-1:0]          out_data,
   output logic [SEL_W-1:0]              out_idx,
   output logic                          out_last,
   output logic                          done,
   output logic [1:0]                    dbg_state
);

   // Stream handshake: a beat transfers on a rising edge where out_valid & out_ready; while
   // out_valid is high and out_ready low, out_data/out_idx/out_last hold unchanged.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [NUM_FIELDS*FIELD_W-1:0]   r_data;
   logic                            r_mode;
   logic [SEL_W-1:0]                r_hi;
   logic [SEL_W-1:0]                r_lo;
   logic [SEL_W-1:0]                r_idx;
   logic                            r_up;

   logic                            w_accept;
   logic                            w_hs;
   logic                            w_last;
   logic                            w_emit;
   logic [SEL_W-1:0]                w_hi_c;
   logic [SEL_W-1:0]                w_lo_c;
   logic [FIELD_W-1:0]              w_fld_idx;
   logic [FIELD_W-1:0]              w_fld_hi;
   logic [FIELD_W-1:0]              w_fld_lo;

   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
      if (int'(s) >= NUM_FIELDS) return SEL_W'(NUM_FIELDS - 1);
      else                       return s;
   endfunction

   assign w_hi_c    = clamp_sel(hi_sel);
   assign w_lo_c    = clamp_sel(lo_sel);
   assign w_emit    = (r_state == ST_EMIT);
   assign w_accept  = (r_state == ST_IDLE) && start;
   assign w_hs      = w_emit && out_ready;
   assign w_last    = w_emit && (!r_mode || (r_idx == r_lo));

   assign w_fld_idx = r_data[int'(r_idx)*FIELD_W +: FIELD_W];
   assign w_fld_hi  = r_data[int'(r_hi)*FIELD_W +: FIELD_W];
   assign w_fld_lo  = r_data[int'(r_lo)*FIELD_W +: FIELD_W];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)        w_state_nxt = ST_EMIT;
         ST_EMIT: if (w_hs && w_last) w_state_nxt = ST_FIN;
         ST_FIN:                    w_state_nxt = ST_IDLE;
         default:                   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Direction is fixed at latch time so later input changes cannot disturb the walk.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_mode <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_idx  <= '0;
         r_up   <= 1'b0;
      end else if (w_accept) begin
         r_data <= data_in;
         r_mode <= mode;
         r_hi   <= w_hi_c;
         r_lo   <= w_lo_c;
         r_idx  <= w_hi_c;
         r_up   <= (w_lo_c > w_hi_c);
      end else if (w_hs && !w_last) begin
         r_idx  <= r_up ? (r_idx + SEL_W'(1)) : (r_idx - SEL_W'(1));
      end
   end

   assign busy      = w_emit;
   assign out_valid = w_emit;
   assign out_last  = w_last;
   assign done      = (r_state == ST_FIN);
   assign out_idx   = w_emit ? r_idx : '0;
   assign out_data  = !w_emit ? '0 :
                      r_mode  ? {{FIELD_W{1'b0}}, w_fld_idx} : {w_fld_hi, w_fld_lo};
   assign dbg_state = r_state;

endmodule

// File: tb/tb_code_comb_stream.sv
// Directed bench for code_comb_stream with data_in = 32'h76543210, so field[i] == i.
module tb_code_comb_stream;

   logic        sysclk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [31:0] data_in;
   logic [2:0]  hi_sel;
   logic [2:0]  lo_sel;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        done;
   logic [1:0]  dbg_state;

   int n_pass = 0;
   int n_chk  = 0;
   int n_done = 0;

   code_comb_stream #(.FIELD_W(4), .NUM_FIELDS(8), .SEL_W(3)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .start(start), .mode(mode), .data_in(data_in),
      .hi_sel(hi_sel), .lo_sel(lo_sel), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .done(done), .dbg_state(dbg_state)
   );

   always #5 sysclk = ~sysclk;

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_beat(input string tag, input logic [7:0] d, input logic [2:0] i,
                           input logic l);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_busy"},  32'(busy),      32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(d));
      chk({tag, "_idx"},   32'(out_idx),   32'(i));
      chk({tag, "_last"},  32'(out_last),  32'(l));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_data"},  32'(out_data),  32'd0);
      chk({tag, "_idx"},   32'(out_idx),   32'd0);
      chk({tag, "_last"},  32'(out_last),  32'd0);
   endtask

   task automatic launch(input logic m, input logic [2:0] hs, input logic [2:0] ls);
      start  = 1'b1;
      mode   = m;
      hi_sel = hs;
      lo_sel = ls;
      step();
      start  = 1'b0;
   endtask

   task automatic chk_fin(input string tag);
      chk({tag, "_done"},  32'(done),      32'd1);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      mode      = 1'b0;
      data_in   = 32'h76543210;
      hi_sel    = 3'd0;
      lo_sel    = 3'd0;
      out_ready = 1'b0;
      step();
      step();
      chk_idle("rst");
      rst_n = 1'b1;
      step();
      chk_idle("idle");

      // PAIR M=1 m=1
      out_ready = 1'b1;
      launch(1'b0, 3'd1, 3'd1);
      chk_beat("pair11", 8'h11, 3'd1, 1'b1);
      step();
      chk_fin("pair11_fin");
      step();
      chk_idle("pair11_after");

      // SWEEP 7 -> 0, back-to-back
      launch(1'b1, 3'd7, 3'd0);
      for (int k = 0; k < 8; k++) begin
         chk_beat($sformatf("dn%0d", k), {4'h0, 4'(7 - k)}, 3'(7 - k), (k == 7));
         step();
      end
      chk_fin("dn_fin");
      step();

      // SWEEP 0 -> 7
      launch(1'b1, 3'd0, 3'd7);
      for (int k = 0; k < 8; k++) begin
         chk_beat($sformatf("up%0d", k), {4'h0, 4'(k)}, 3'(k), (k == 7));
         step();
      end
      chk_fin("up_fin");
      step();

      // SWEEP 5 -> 5
      launch(1'b1, 3'd5, 3'd5);
      chk_beat("sw55", 8'h05, 3'd5, 1'b1);
      step();
      chk_fin("sw55_fin");
      step();

      // PAIR 6,1 under backpressure, with a start while busy and in FIN
      out_ready = 1'b0;
      launch(1'b0, 3'd6, 3'd1);
      start = 1'b1; mode = 1'b1; hi_sel = 3'd0; lo_sel = 3'd7;
      chk_beat("bp0", 8'h61, 3'd6, 1'b1);
      step();
      chk_beat("bp1", 8'h61, 3'd6, 1'b1);
      step();
      out_ready = 1'b1;
      chk_beat("bp2", 8'h61, 3'd6, 1'b1);
      step();
      chk_fin("bp_fin");
      step();
      chk_idle("bp_after");
      start = 1'b0;
      step();
      chk_idle("bp_idle");

      // SWEEP 2 -> 4, inputs changed after accept
      launch(1'b1, 3'd2, 3'd4);
      data_in = 32'hFFFFFFFF; hi_sel = 3'd7; lo_sel = 3'd0; mode = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk_beat($sformatf("lat%0d", k), {4'h0, 4'(2 + k)}, 3'(2 + k), (k == 2));
         step();
      end
      n_done = 0;
      for (int k = 0; k < 4; k++) begin
         if (done) n_done++;
         step();
      end
      chk("lat_done_count", 32'(n_done), 32'd1);
      data_in = 32'h76543210;

      // clamp: indices are 3 bits so nothing exceeds 7; 7 -> 7 stays at the top
      launch(1'b1, 3'd7, 3'd7);
      chk_beat("top77", 8'h07, 3'd7, 1'b1);
      step();
      step();

      // reset mid-SWEEP
      launch(1'b1, 3'd7, 3'd0);
      step();
      step();
      step();
      chk_beat("pre_rst", 8'h04, 3'd4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_idle("mid_rst");
      step();
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 3; k++) begin
         if (done || out_valid) n_done++;
         step();
      end
      chk("rst_no_activity", 32'(n_done), 32'd0);
      launch(1'b0, 3'd3, 3'd2);
      chk_beat("post_rst", 8'h32, 3'd3, 1'b1);
      step();
      chk_fin("post_rst_fin");
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
